// File: rtl/bomb_scheduler_if.sv
// Detonation handoff between the bomb scheduler and the stage-update logic.
interface bomb_scheduler_if;
    logic       explode_valid;
    logic [2:0] explode_id;
    logic [3:0] explode_x;
    logic [3:0] explode_y;
    logic       explode_owner;
    logic       explode_ready;

    modport master (
        output explode_valid, explode_id, explode_x, explode_y, explode_owner,
        input  explode_ready
    );

    modport slave (
        input  explode_valid, explode_id, explode_x, explode_y, explode_owner,
        output explode_ready
    );
endinterface

// File: rtl/bomb_scheduler.sv
// Six-slot bomb table: placement arbitration, fuse/blast timers on the
// 60 Hz tick, detonation handshake and a combinational slot read port.
module bomb_scheduler #(
    parameter int NUM_BOMBS      = 6,
    parameter int FUSE_TICKS     = 180,
    parameter int BLAST_TICKS    = 30,
    parameter int MAX_PER_PLAYER = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       p1_req,
    input  logic       p2_req,
    input  logic [3:0] p1_x,
    input  logic [3:0] p1_y,
    input  logic [3:0] p2_x,
    input  logic [3:0] p2_y,
    output logic       p1_ack,
    output logic       p2_ack,
    output logic       p1_nack,
    output logic       p2_nack,
    output logic [2:0] p1_count,
    output logic [2:0] p2_count,
    input  logic       chain_valid,
    input  logic [3:0] chain_x,
    input  logic [3:0] chain_y,
    input  logic [2:0] read_id,
    output logic       read_armed,
    output logic       read_blast,
    output logic [3:0] read_x,
    output logic [3:0] read_y,
    output logic       read_owner,
    bomb_scheduler_if.master ex
);

    typedef enum logic [1:0] {S_FREE, S_ARMED, S_PENDING, S_BLAST} slot_e;

    slot_e      st_q  [NUM_BOMBS];
    slot_e      st_d  [NUM_BOMBS];
    logic [3:0] x_q   [NUM_BOMBS];
    logic [3:0] x_d   [NUM_BOMBS];
    logic [3:0] y_q   [NUM_BOMBS];
    logic [3:0] y_d   [NUM_BOMBS];
    logic       own_q [NUM_BOMBS];
    logic       own_d [NUM_BOMBS];
    logic [7:0] tmr_q [NUM_BOMBS];
    logic [7:0] tmr_d [NUM_BOMBS];

    logic       ptr_q, ptr_d;
    logic       p1_ack_q, p1_ack_d, p2_ack_q, p2_ack_d;
    logic       p1_nack_q, p1_nack_d, p2_nack_q, p2_nack_d;
    logic [2:0] p1_cnt_q, p1_cnt_d, p2_cnt_q, p2_cnt_d;

    logic       r1, r2, srv1, srv2, srv;
    logic [3:0] rx, ry;
    logic       rown;
    logic [2:0] own_cnt;
    logic       free_found, dup, place;
    logic [2:0] free_idx;
    logic       pend_found, accept;
    logic [2:0] pend_idx;
    logic [2:0] dec1, dec2;

    always_comb begin
        // A player whose response is on the wire this clock is not re-decided.
        r1   = p1_req & ~(p1_ack_q | p1_nack_q);
        r2   = p2_req & ~(p2_ack_q | p2_nack_q);
        srv2 = r2 & (~r1 | ptr_q);
        srv1 = r1 & ~srv2;
        srv  = srv1 | srv2;
        ptr_d = (r1 & r2) ? ~ptr_q : ptr_q;

        rx      = srv2 ? p2_x : p1_x;
        ry      = srv2 ? p2_y : p1_y;
        rown    = srv2;
        own_cnt = srv2 ? p2_cnt_q : p1_cnt_q;

        free_found = 1'b0;
        free_idx   = '0;
        dup        = 1'b0;
        pend_found = 1'b0;
        pend_idx   = '0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            if (st_q[i] == S_FREE && !free_found) begin
                free_found = 1'b1;
                free_idx   = 3'(i);
            end
            if (st_q[i] != S_FREE && x_q[i] == rx && y_q[i] == ry)
                dup = 1'b1;
            if (st_q[i] == S_PENDING && !pend_found) begin
                pend_found = 1'b1;
                pend_idx   = 3'(i);
            end
        end

        place  = srv & free_found & ~dup &
                 (own_cnt < 3'(MAX_PER_PLAYER));
        accept = pend_found & ex.explode_ready;

        p1_ack_d  = srv1 & place;
        p2_ack_d  = srv2 & place;
        p1_nack_d = srv1 & ~place;
        p2_nack_d = srv2 & ~place;

        dec1 = '0;
        dec2 = '0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
            st_d[i]  = st_q[i];
            x_d[i]   = x_q[i];
            y_d[i]   = y_q[i];
            own_d[i] = own_q[i];
            tmr_d[i] = tmr_q[i];
            unique case (st_q[i])
                S_FREE: begin
                    if (place && free_idx == 3'(i)) begin
                        st_d[i]  = S_ARMED;
                        x_d[i]   = rx;
                        y_d[i]   = ry;
                        own_d[i] = rown;
                        tmr_d[i] = 8'(FUSE_TICKS);
                    end
                end
                S_ARMED: begin
                    if (chain_valid && x_q[i] == chain_x && y_q[i] == chain_y) begin
                        st_d[i] = S_PENDING;
                    end else if (tick) begin
                        tmr_d[i] = tmr_q[i] - 8'd1;
                        if (tmr_q[i] == 8'd1)
                            st_d[i] = S_PENDING;
                    end
                end
                S_PENDING: begin
                    if (accept && pend_idx == 3'(i)) begin
                        st_d[i]  = S_BLAST;
                        tmr_d[i] = 8'(BLAST_TICKS);
                    end
                end
                S_BLAST: begin
                    if (tick) begin
                        tmr_d[i] = tmr_q[i] - 8'd1;
                        if (tmr_q[i] == 8'd1) begin
                            st_d[i]  = S_FREE;
                            x_d[i]   = '0;
                            y_d[i]   = '0;
                            own_d[i] = 1'b0;
                            if (own_q[i]) dec2 = dec2 + 3'd1;
                            else          dec1 = dec1 + 3'd1;
                        end
                    end
                end
                default: st_d[i] = S_FREE;
            endcase
        end

        p1_cnt_d = p1_cnt_q + 3'(p1_ack_d) - dec1;
        p2_cnt_d = p2_cnt_q + 3'(p2_ack_d) - dec2;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_BOMBS; i++) begin
                st_q[i]  <= S_FREE;
                x_q[i]   <= '0;
                y_q[i]   <= '0;
                own_q[i] <= 1'b0;
                tmr_q[i] <= '0;
            end
            ptr_q     <= 1'b0;
            p1_ack_q  <= 1'b0;
            p2_ack_q  <= 1'b0;
            p1_nack_q <= 1'b0;
            p2_nack_q <= 1'b0;
            p1_cnt_q  <= '0;
            p2_cnt_q  <= '0;
        end else begin
            st_q      <= st_d;
            x_q       <= x_d;
            y_q       <= y_d;
            own_q     <= own_d;
            tmr_q     <= tmr_d;
            ptr_q     <= ptr_d;
            p1_ack_q  <= p1_ack_d;
            p2_ack_q  <= p2_ack_d;
            p1_nack_q <= p1_nack_d;
            p2_nack_q <= p2_nack_d;
            p1_cnt_q  <= p1_cnt_d;
            p2_cnt_q  <= p2_cnt_d;
        end
    end

    assign p1_ack   = p1_ack_q;
    assign p2_ack   = p2_ack_q;
    assign p1_nack  = p1_nack_q;
    assign p2_nack  = p2_nack_q;
    assign p1_count = p1_cnt_q;
    assign p2_count = p2_cnt_q;

    assign ex.explode_valid = pend_found;
    assign ex.explode_id    = pend_idx;
    assign ex.explode_x     = pend_found ? x_q[pend_idx] : '0;
    assign ex.explode_y     = pend_found ? y_q[pend_idx] : '0;
    assign ex.explode_owner = pend_found & own_q[pend_idx];

    always_comb begin
        read_armed = 1'b0;
        read_blast = 1'b0;
        read_x     = '0;
        read_y     = '0;
        read_owner = 1'b0;
        if (read_id < 3'(NUM_BOMBS)) begin
            if (st_q[read_id] != S_FREE) begin
                read_armed = st_q[read_id] == S_ARMED ||
                             st_q[read_id] == S_PENDING;
                read_blast = st_q[read_id] == S_BLAST;
                read_x     = x_q[read_id];
                read_y     = y_q[read_id];
                read_owner = own_q[read_id];
            end
        end
    end

endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed bench for bomb_scheduler: placement, arbitration, fuse,
// chain, handshake, blast/free and reset.
module tb_bomb_scheduler;

    logic       clock = 1'b0;
    logic       reset, tick;
    logic       p1_req, p2_req;
    logic [3:0] p1_x, p1_y, p2_x, p2_y;
    logic       p1_ack, p2_ack, p1_nack, p2_nack;
    logic [2:0] p1_count, p2_count;
    logic       chain_valid;
    logic [3:0] chain_x, chain_y;
    logic [2:0] read_id;
    logic       read_armed, read_blast, read_owner;
    logic [3:0] read_x, read_y;

    int vectors = 0;
    int miscompares = 0;

    bomb_scheduler_if ex_if ();

    bomb_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .p1_req      (p1_req),
        .p2_req      (p2_req),
        .p1_x        (p1_x),
        .p1_y        (p1_y),
        .p2_x        (p2_x),
        .p2_y        (p2_y),
        .p1_ack      (p1_ack),
        .p2_ack      (p2_ack),
        .p1_nack     (p1_nack),
        .p2_nack     (p2_nack),
        .p1_count    (p1_count),
        .p2_count    (p2_count),
        .chain_valid (chain_valid),
        .chain_x     (chain_x),
        .chain_y     (chain_y),
        .read_id     (read_id),
        .read_armed  (read_armed),
        .read_blast  (read_blast),
        .read_x      (read_x),
        .read_y      (read_y),
        .read_owner  (read_owner),
        .ex          (ex_if.master)
    );

    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step(1);
            tick = 1'b0;
            step(1);
        end
    endtask

    // Returns {ack, nack} of the requesting player; req dropped afterwards.
    task automatic place(input bit who, input logic [3:0] x,
                         input logic [3:0] y, output logic [1:0] resp);
        if (who) begin
            p2_req = 1'b1; p2_x = x; p2_y = y;
        end else begin
            p1_req = 1'b1; p1_x = x; p1_y = y;
        end
        step(1);
        resp = who ? {p2_ack, p2_nack} : {p1_ack, p1_nack};
        p1_req = 1'b0;
        p2_req = 1'b0;
        step(1);
    endtask

    task automatic slot(input string tag, input logic [2:0] id,
                        input logic [11:0] exp);
        read_id = id;
        #1;
        check(tag, {read_armed, read_blast, read_owner, 1'b0, read_x, read_y},
              {20'd0, exp});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    localparam logic [1:0] ACK  = 2'b10;
    localparam logic [1:0] NACK = 2'b01;

    logic [1:0] r;

    initial begin
        reset = 1'b1; tick = 1'b0;
        p1_req = 1'b0; p2_req = 1'b0;
        p1_x = '0; p1_y = '0; p2_x = '0; p2_y = '0;
        chain_valid = 1'b0; chain_x = '0; chain_y = '0;
        read_id = '0;
        ex_if.explode_ready = 1'b0;
        step(2);
        reset = 1'b0;

        check("rst_valid", ex_if.explode_valid, 0);
        check("rst_counts", {p1_count, p2_count}, 0);
        check("rst_resp", {p1_ack, p2_ack, p1_nack, p2_nack}, 0);
        slot("rst_slot0", 0, 12'h000);

        // single placement, fuse and blast
        place(0, 3, 5, r);
        check("t1_ack", r, ACK);
        slot("t1_slot0", 0, {4'b1000, 4'd3, 4'd5});
        check("t1_cnt", p1_count, 1);
        ticks(179);
        check("t1_179", ex_if.explode_valid, 0);
        ticks(1);
        check("t1_180", {ex_if.explode_valid, ex_if.explode_id,
              ex_if.explode_x, ex_if.explode_y, ex_if.explode_owner},
              {1'b1, 3'd0, 4'd3, 4'd5, 1'b0});
        slot("t1_pend_armed", 0, {4'b1000, 4'd3, 4'd5});
        ex_if.explode_ready = 1'b1;
        step(1);
        ex_if.explode_ready = 1'b0;
        check("t1_acc_valid", ex_if.explode_valid, 0);
        slot("t1_blast", 0, {4'b0100, 4'd3, 4'd5});
        ticks(29);
        slot("t1_blast29", 0, {4'b0100, 4'd3, 4'd5});
        ticks(1);
        slot("t1_free", 0, 12'h000);
        check("t1_cnt0", p1_count, 0);

        // dual request arbitration
        p1_req = 1'b1; p1_x = 1; p1_y = 1;
        p2_req = 1'b1; p2_x = 2; p2_y = 2;
        step(1);
        check("t2_first", {p1_ack, p2_ack, p1_nack, p2_nack}, 4'b1000);
        p1_req = 1'b0;
        step(1);
        check("t2_second", {p1_ack, p2_ack, p1_nack, p2_nack}, 4'b0100);
        p2_req = 1'b0;
        step(1);
        slot("t2_slot1", 1, {4'b1010, 4'd2, 4'd2});
        p1_req = 1'b1; p1_x = 6; p1_y = 6;
        p2_req = 1'b1; p2_x = 7; p2_y = 7;
        step(1);
        check("t2_rr_first", {p1_ack, p2_ack}, 2'b01);
        p2_req = 1'b0;
        step(1);
        check("t2_rr_second", {p1_ack, p2_ack}, 2'b10);
        p1_req = 1'b0;
        step(1);
        slot("t2_slot3", 3, {4'b1000, 4'd6, 4'd6});

        // limits: per-player, duplicate tile, table full
        place(0, 8, 8, r);
        check("t3_p1_third", r, ACK);
        place(0, 9, 9, r);
        check("t3_p1_fourth", r, NACK);
        check("t3_p1_cnt", p1_count, 3);
        place(1, 1, 1, r);
        check("t3_dup", r, NACK);
        check("t3_p2_cnt", p2_count, 2);
        place(1, 10, 10, r);
        check("t3_p2_third", r, ACK);
        place(1, 11, 11, r);
        check("t3_full", r, NACK);
        slot("t3_rd_oob", 7, 12'h000);

        // stall with ready low, then accept
        ticks(180);
        check("t4_valid", ex_if.explode_valid, 1);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t4_stable", {ex_if.explode_valid, ex_if.explode_id,
                  ex_if.explode_x}, {1'b1, 3'd0, 4'd1});
        end
        ex_if.explode_ready = 1'b1;
        step(1);
        ex_if.explode_ready = 1'b0;
        slot("t4_slot0_blast", 0, {4'b0100, 4'd1, 4'd1});
        check("t4_next_id", {ex_if.explode_id, ex_if.explode_owner},
              {3'd1, 1'b1});

        do_reset();
        check("t4_rst", {ex_if.explode_valid, p1_count, p2_count}, 0);

        // chain reaction, blast free and same-clock reuse
        place(0, 4, 4, r);
        check("t5_ack", r, ACK);
        ticks(80);
        chain_valid = 1'b1; chain_x = 4; chain_y = 5;
        step(1);
        chain_valid = 1'b0;
        check("t5_chain_miss", ex_if.explode_valid, 0);
        chain_valid = 1'b1; chain_y = 4; tick = 1'b1;
        step(1);
        chain_valid = 1'b0; tick = 1'b0;
        check("t5_chain_hit", {ex_if.explode_valid, ex_if.explode_id}, 4'b1000);
        ex_if.explode_ready = 1'b1;
        step(1);
        ex_if.explode_ready = 1'b0;
        ticks(29);
        slot("t5_blast29", 0, {4'b0100, 4'd4, 4'd4});
        check("t5_cnt1", p1_count, 1);
        tick = 1'b1; p1_req = 1'b1; p1_x = 6; p1_y = 6;
        step(1);
        tick = 1'b0; p1_req = 1'b0;
        check("t5_same_ack", p1_ack, 1);
        check("t5_cancel", p1_count, 1);
        step(1);
        slot("t5_slot1", 1, {4'b1000, 4'd6, 4'd6});
        slot("t5_slot0_free", 0, 12'h000);
        place(1, 5, 5, r);
        check("t5_reuse_ack", r, ACK);
        slot("t5_reuse", 0, {4'b1010, 4'd5, 4'd5});

        // dual request moves the pointer to P2, then reset mid-detonation
        p1_req = 1'b1; p1_x = 7; p1_y = 7;
        p2_req = 1'b1; p2_x = 9; p2_y = 9;
        step(1);
        check("t6_dual", {p1_ack, p2_ack}, 2'b10);
        p1_req = 1'b0;
        step(1);
        check("t6_p2", p2_ack, 1);
        p2_req = 1'b0;
        chain_valid = 1'b1; chain_x = 9; chain_y = 9;
        step(1);
        chain_valid = 1'b0;
        check("t6_pre_valid", ex_if.explode_valid, 1);
        check("t6_pre_cnt", {p1_count, p2_count}, {3'd2, 3'd2});
        do_reset();
        check("t6_rst_out", {ex_if.explode_valid, ex_if.explode_id,
              p1_count, p2_count}, 0);
        for (int i = 0; i < 6; i++)
            slot("t6_rst_slot", 3'(i), 12'h000);
        p1_req = 1'b1; p1_x = 1; p1_y = 2;
        p2_req = 1'b1; p2_x = 3; p2_y = 4;
        step(1);
        check("t6_p1_first", {p1_ack, p2_ack}, 2'b10);
        p1_req = 1'b0; p2_req = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bomb_scheduler.md
Name: bomb_scheduler

Overview:
- Owns the six bomb slots whose index is swept by the control FSM's bomb counter when it draws bombs.
- Arbitrates bomb-placement requests from P1 and P2, runs the fuse and blast timers off the 60 Hz tick, and hands each detonation to the stage-update logic over a valid/ready handshake.
- Exposes a zero-latency read port indexed by bomb_id so the bomb-draw states can fetch slot position and status.

Parameters:
- NUM_BOMBS, 6: number of slots. Slot index is 3 bits.
- FUSE_TICKS, 180: ticks from placement to detonation (3 s at 60 Hz). Must be ≤255.
- BLAST_TICKS, 30: ticks a slot stays in blast before it is freed. Must be ≤255.
- MAX_PER_PLAYER, 3: maximum non-free slots owned by one player. Must be ≤NUM_BOMBS.

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high
- tick  in  1  one-clock pulse at 60 Hz
- p1_req, p2_req  in  1 each  placement request; level, held until ack or nack
- p1_x, p1_y, p2_x, p2_y  in  4 each  requested tile coordinate
- p1_ack, p2_ack, p1_nack, p2_nack  out  1 each  one-clock response pulses
- p1_count, p2_count  out  3 each  owned non-free slots
- chain_valid  in  1  blast reached tile (chain_x, chain_y)
- chain_x, chain_y  in  4 each  tile coordinate for chain_valid
- read_id  in  3  slot select
- read_armed, read_blast  out  1 each  status of the selected slot
- read_x, read_y  out  4 each  tile of the selected slot
- read_owner  out  1  owner of the selected slot; 0 = P1, 1 = P2
- explode_valid  out  1  a detonation is pending
- explode_id  out  3  slot index of the pending detonation
- explode_x, explode_y  out  4 each  tile of the pending detonation
- explode_owner  out  1  owner of the pending detonation
- explode_ready  in  1  consumer accepts the detonation

Behaviour:
- Clock and reset: one clock, `clock`; `reset` is synchronous and active-high.
- Reset effects: every slot goes FREE with its timer cleared; all outputs are 0; the round-robin pointer points to P1. Reset mid-operation discards pending detonations without a handshake.
- Slot states: FREE, ARMED, PENDING, BLAST. Each slot also holds x, y, owner and an 8-bit timer.
- Arbitration:
  - At most one placement is decided per clock.
  - If only one request is high, it is served.
  - If both are high, the pointer's player is served, then the pointer flips to the other player.
  - The unserved request receives no response; it stays high and is decided on a later clock.
- Placement decision, for the served player:
  - nack if owned count == MAX_PER_PLAYER, or no slot is FREE, or any non-FREE slot already holds the same (x, y).
  - Otherwise the lowest-index FREE slot becomes ARMED with timer = FUSE_TICKS and the owner recorded; ack pulses and the count increments.
  - ack/nack is registered and appears the clock after the request is sampled.
  - The served request must not be re-decided on the following clock; the requester drops req on seeing the response.
- Fuse timing:
  - On tick, every ARMED slot decrements its timer.
  - A slot whose timer is 1 at tick becomes PENDING.
  - A slot armed in the same clock as a tick is not decremented that clock.
- Chain reaction: on chain_valid, any ARMED slot with matching (x, y) becomes PENDING next clock. If it coincides with a tick, chain wins.
- Detonation handshake:
  - explode_valid = any slot PENDING.
  - explode_id, x, y and owner describe the lowest-index PENDING slot. They are driven from registers only, with no combinational path from explode_ready.
  - These outputs are stable while valid is high and ready is low.
  - On valid & ready, that slot becomes BLAST with timer = BLAST_TICKS.
- Blast and free:
  - On tick, BLAST slots decrement; a slot at 1 becomes FREE and its owner count decrements.
  - A freed slot is usable by a placement one clock later, not in the same clock.
- Counts: increment and decrement of the same player's count in the same clock cancel.
- Read port:
  - Combinational from slot registers.
  - read_id ≥ NUM_BOMBS returns all zeros.
  - x, y and owner read 0 for a FREE slot.
  - read_armed is high for both ARMED and PENDING.

Test Plan:
- P1 requests (3,5) → p1_ack one clock later, slot 0 ARMED; after 179 ticks, explode_valid=0; on tick 180, explode_valid=1, explode_id=0, explode_x=3, explode_y=5.
- Both request in the same clock, P1 at (1,1), P2 at (2,2) → first decision p1_ack with slot 0; next decision p2_ack with slot 1; in the next dual-request round P2 is served first.
- P1 places 3 bombs, then a 4th → p1_nack with p1_count=3. P2 requests P1's occupied tile → p2_nack. Fill all 6 slots, then one more request → nack.
- Two bombs pending with explode_ready held low for 10 clocks → explode_id=0 stable throughout; assert ready for 1 clock → slot 0 enters BLAST and explode_id changes to 1.
- chain_valid at (4,4) with an ARMED bomb there at timer=100 → PENDING next clock; after BLAST_TICKS=30 ticks post-accept → FREE, owner count decrements, and the slot is reused by the next request.
- Assert reset while 4 slots are active and explode_valid=1 → next clock all read_* = 0, explode_valid=0, counts=0; a subsequent dual request is served P1 first.
